tlb_mmu_mp: RTL and testbench
=============================

TLB_MMU_MP -- requirements
Module: tlb_mmu_mp

Interface
REQ-001 SHALL have parameter TLB_ENTRY_NUM, default 32, number of TLB entries, power of two, 4..64.
REQ-002 SHALL have parameter PORT_NUM, default 2, number of independent translation ports (port 0 fetch, others load/store).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-high (asserted = 1).
REQ-005 SHALL have port flush  in  1  drops all in-flight lookup results.
REQ-006 SHALL have port csr  in  csr_t  crmd, asid, dmw0, dmw1 snapshot.
REQ-007 SHALL have ports lk_valid_i [PORT_NUM], lk_va_i [PORT_NUM][32], lk_mem_type_i [PORT_NUM][2]  in  per-port lookup request.
REQ-008 SHALL have port lk_result_o  out  trans_result_t[PORT_NUM]  registered fields: valid, pa[31:0], mat[1:0], exc, ecode.
REQ-009 SHALL have ports mt_valid_i in 1, mt_ready_o out 1, mt_req_i in tlb_maint_req_t (op, index, entry, inv_op, asid, va): maintenance request handshake.
REQ-010 SHALL have ports mt_resp_valid_o out 1, mt_resp_o out tlb_maint_resp_t (found, index, entry): one-cycle maintenance response pulse.
REQ-011 SHALL have port busy_o  out  1  high while an invalidate sweep is in progress.

Function
REQ-012 Lookup latency SHALL be exactly one cycle: request sampled at edge N, lk_result_o valid after edge N; no back-pressure on lookup ports.
REQ-013 Translation priority SHALL be: crmd.DA (pa=va, mat=DATF for fetch else DATM) > DMW0 hit > DMW1 hit > TLB.
REQ-014 DMW hit SHALL require va[31:29]==VSEG and PLV enable bit for current PLV (0 or 3); pa={PSEG,va[28:0]}.
REQ-015 TLB match SHALL require e=1, (g=1 or asid==csr.asid), and va[31:13]==vppn for 4KB or va[31:22]==vppn[18:9] for huge page.
REQ-016 Odd/even half SHALL be selected by va[12] (4KB, pa={ppn,va[11:0]}) or va[21] (huge, pa={ppn[19:9],va[20:0]}).
REQ-017 Multiple hits SHALL be impossible by software contract; the lowest matching index SHALL win deterministically.
REQ-018 TLB exceptions SHALL be flagged in order: miss->TLBR; v=0->PIF/PIL/PIS by mem_type; PLV>entry.plv->PPI; store with d=0->PME; exc=1 forces valid=0.
REQ-019 Output valid SHALL be 0 when lk_valid_i was 0, when flush was high at the sampling edge, or when busy_o was high.
REQ-020 Maintenance FSM SHALL have states IDLE, SWEEP, RESP; mt_ready_o=1 only in IDLE; request accepted when mt_valid_i & mt_ready_o.
REQ-021 SRCH and RD SHALL go IDLE->RESP; response (found/index for SRCH, entry for RD, found=e) valid the next cycle, then IDLE.
REQ-022 WR SHALL write mt_req_i.entry to index at accept edge; FILL SHALL write to fill_ptr; both go to RESP with index written.
REQ-023 fill_ptr SHALL be a free-running counter modulo TLB_ENTRY_NUM, incrementing every cycle outside reset.
REQ-024 INV SHALL go IDLE->SWEEP, clearing e of one entry per cycle (index 0..TLB_ENTRY_NUM-1) per inv_op 0/1 all, 2 g=1, 3 g=0, 4 g=0&asid, 5 g=0&asid&va, 6 (g=1|asid)&va; then RESP; total TLB_ENTRY_NUM+1 cycles; inv_op 7 SHALL behave as no-op sweep.
REQ-025 A lookup in the same cycle as a WR/FILL accept SHALL see the pre-write contents.
REQ-026 flush SHALL NOT abort a maintenance operation in progress.

Reset
REQ-027 On reset SHALL: all entry e=0, FSM=IDLE, fill_ptr=0, lk_result_o='0, mt_resp_valid_o=0, mt_resp_o='0, busy_o=0, mt_ready_o=1 after release.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep immediately, with no response pulse.

Structure
REQ-029 tlb_key_t, tlb_value_t, tlb_entry_t, trans_result_t, tlb_maint_req_t, tlb_maint_resp_t, op/inv_op/ecode and mem_type encodings SHALL live in the shared MMU package.
REQ-030 Per-port match/translate logic SHALL be one sub-module, tlb_lookup_port, instantiated PORT_NUM times over shared entry storage.

Verification
REQ-031 DA=1, va=0x1234_5678 load -> next cycle valid=1, pa=0x1234_5678, mat=DATM.
REQ-032 WR index 3 {vppn=0x00010, 4KB, asid=5, v1=1, ppn1=0xABCDE, d=1}, asid=5, load va=0x0002_1F00 -> pa=0xABCDE_F00, exc=0.
REQ-033 Same entry, store with d1=0 -> exc=1, ecode=PME, valid=0; asid=6 with g=0 -> ecode=TLBR.
REQ-034 INV inv_op=0 with TLB_ENTRY_NUM=32 -> busy_o high 32 cycles, resp pulse cycle 33, subsequent SRCH found=0.
REQ-035 Port 0 and port 1 lookups same cycle, flush asserted -> both valid=0; next-cycle repeat without flush -> both translate correctly.
REQ-036 Reset asserted at sweep cycle 10 -> busy_o=0, no mt_resp_valid_o, all entries e=0 after release.

Source files
------------

// File: rtl/tlb_mmu_mp_pkg.sv
// Shared MMU types: CSR snapshot, TLB entry layout, lookup result,
// maintenance request/response, and the op / inv_op / ecode / mem_type
// encodings. Also holds the match helpers, so the lookup ports and the
// maintenance search use the same compare.
package tlb_mmu_mp_pkg;

    // Maintenance index field is sized for the largest legal TLB (64 entries).
    localparam int TLB_IDX_W = 6;

    localparam logic [1:0] MEM_FETCH = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    localparam logic [2:0] INV_ALL0       = 3'd0;
    localparam logic [2:0] INV_ALL1       = 3'd1;
    localparam logic [2:0] INV_G1         = 3'd2;
    localparam logic [2:0] INV_G0         = 3'd3;
    localparam logic [2:0] INV_G0_ASID    = 3'd4;
    localparam logic [2:0] INV_G0_ASID_VA = 3'd5;
    localparam logic [2:0] INV_GA_VA      = 3'd6;

    typedef enum logic [2:0] {OP_SRCH, OP_RD, OP_WR, OP_FILL, OP_INV} tlb_op_e;

    typedef enum logic [2:0] {
        EC_NONE, EC_TLBR, EC_PIF, EC_PIL, EC_PIS, EC_PPI, EC_PME
    } ecode_e;

    typedef struct packed {
        logic       da;
        logic [1:0] plv;
        logic [1:0] datf;
        logic [1:0] datm;
    } crmd_t;

    typedef struct packed {
        logic [2:0] vseg;
        logic [2:0] pseg;
        logic [1:0] mat;
        logic       plv3;
        logic       plv0;
    } dmw_t;

    typedef struct packed {
        crmd_t      crmd;
        logic [9:0] asid;
        dmw_t       dmw0;
        dmw_t       dmw1;
    } csr_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic        huge;   // 1: 4MB page pair, 0: 4KB page pair
        logic        g;
        logic [9:0]  asid;
        logic        e;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_value_t;

    typedef struct packed {
        tlb_key_t   key;
        tlb_value_t v0;     // even half
        tlb_value_t v1;     // odd half
    } tlb_entry_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pa;
        logic [1:0]  mat;
        logic        exc;
        ecode_e      ecode;
    } trans_result_t;

    typedef struct packed {
        tlb_op_e              op;
        logic [TLB_IDX_W-1:0] index;
        tlb_entry_t           entry;
        logic [2:0]           inv_op;
        logic [9:0]           asid;
        logic [31:0]          va;
    } tlb_maint_req_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
        tlb_entry_t           entry;
    } tlb_maint_resp_t;

    function automatic logic va_match(tlb_key_t k, logic [31:0] va);
        return k.huge ? (va[31:22] == k.vppn[18:9]) : (va[31:13] == k.vppn);
    endfunction

    function automatic logic tlb_match(tlb_key_t k, logic [31:0] va, logic [9:0] asid);
        return k.e && (k.g || (k.asid == asid)) && va_match(k, va);
    endfunction

    function automatic logic dmw_hit(dmw_t d, logic [1:0] plv, logic [31:0] va);
        return (va[31:29] == d.vseg) &&
               (((plv == 2'd0) && d.plv0) || ((plv == 2'd3) && d.plv3));
    endfunction

    // Selects which entries an invalidate sweep clears. Codes 7 and up
    // clear nothing, so the sweep still runs its full length.
    function automatic logic inv_hit(logic [2:0] op, tlb_key_t k,
                                     logic [9:0] asid, logic [31:0] va);
        logic am;
        am = (k.asid == asid);
        case (op)
            INV_ALL0, INV_ALL1: return 1'b1;
            INV_G1:             return k.g;
            INV_G0:             return !k.g;
            INV_G0_ASID:        return !k.g && am;
            INV_G0_ASID_VA:     return !k.g && am && va_match(k, va);
            INV_GA_VA:          return (k.g || am) && va_match(k, va);
            default:            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tlb_mmu_mp_if.sv
// Lookup and maintenance bus for tlb_mmu_mp.
//   lk_valid_i / lk_va_i / lk_mem_type_i : per-port lookup request
//   lk_result_o                           : per-port registered result
//   mt_valid_i / mt_ready_o / mt_req_i    : maintenance request handshake
//   mt_resp_valid_o / mt_resp_o           : one-cycle maintenance response
//   busy_o                                : invalidate sweep in progress
// slave = MMU side, master = requester side.
interface tlb_mmu_mp_if #(
    parameter int PORT_NUM = 2
);
    import tlb_mmu_mp_pkg::*;

    logic [PORT_NUM-1:0]            lk_valid_i;
    logic [PORT_NUM-1:0][31:0]      lk_va_i;
    logic [PORT_NUM-1:0][1:0]       lk_mem_type_i;
    trans_result_t [PORT_NUM-1:0]   lk_result_o;

    logic            mt_valid_i;
    logic            mt_ready_o;
    tlb_maint_req_t  mt_req_i;
    logic            mt_resp_valid_o;
    tlb_maint_resp_t mt_resp_o;
    logic            busy_o;

    modport slave (
        input  lk_valid_i, lk_va_i, lk_mem_type_i, mt_valid_i, mt_req_i,
        output lk_result_o, mt_ready_o, mt_resp_valid_o, mt_resp_o, busy_o
    );

    modport master (
        output lk_valid_i, lk_va_i, lk_mem_type_i, mt_valid_i, mt_req_i,
        input  lk_result_o, mt_ready_o, mt_resp_valid_o, mt_resp_o, busy_o
    );

endinterface

// File: rtl/tlb_mmu_mp_lookup.sv
// One translation port: direct-address / DMW / TLB translation plus
// exception classification, with a single registered result stage.
//   clk, rst_n  : clock, async active-high reset
//   en          : request qualified (valid, no flush, no sweep)
//   csr         : crmd/asid/dmw snapshot
//   va, mem_type: request
//   entries     : shared TLB storage (read only)
//   result_o    : registered trans_result_t
module tlb_lookup_port
    import tlb_mmu_mp_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  csr_t                             csr,
    input  logic [31:0]                      va,
    input  logic [1:0]                       mem_type,
    input  tlb_entry_t [TLB_ENTRY_NUM-1:0]   entries,
    output trans_result_t                    result_o
);

    logic          hit;
    logic          hit_huge;
    tlb_value_t    hit_v0, hit_v1, half;
    logic          odd;
    logic [31:0]   tlb_pa;
    trans_result_t res;

    // Software guarantees a single hit; scanning upward with a sticky
    // flag makes the lowest index win if that contract is broken.
    always_comb begin
        hit      = 1'b0;
        hit_huge = 1'b0;
        hit_v0   = '0;
        hit_v1   = '0;
        for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
            if (!hit && tlb_match(entries[i].key, va, csr.asid)) begin
                hit      = 1'b1;
                hit_huge = entries[i].key.huge;
                hit_v0   = entries[i].v0;
                hit_v1   = entries[i].v1;
            end
        end
    end

    assign odd    = hit_huge ? va[21] : va[12];
    assign half   = odd ? hit_v1 : hit_v0;
    assign tlb_pa = hit_huge ? {half.ppn[19:9], va[20:0]} : {half.ppn, va[11:0]};

    always_comb begin
        res = '0;
        if (csr.crmd.da) begin
            res.valid = 1'b1;
            res.pa    = va;
            res.mat   = (mem_type == MEM_FETCH) ? csr.crmd.datf : csr.crmd.datm;
        end else if (dmw_hit(csr.dmw0, csr.crmd.plv, va)) begin
            res.valid = 1'b1;
            res.pa    = {csr.dmw0.pseg, va[28:0]};
            res.mat   = csr.dmw0.mat;
        end else if (dmw_hit(csr.dmw1, csr.crmd.plv, va)) begin
            res.valid = 1'b1;
            res.pa    = {csr.dmw1.pseg, va[28:0]};
            res.mat   = csr.dmw1.mat;
        end else if (!hit) begin
            res.exc   = 1'b1;
            res.ecode = EC_TLBR;
        end else if (!half.v) begin
            res.exc   = 1'b1;
            res.ecode = (mem_type == MEM_FETCH) ? EC_PIF :
                        (mem_type == MEM_STORE) ? EC_PIS : EC_PIL;
        end else if (csr.crmd.plv > half.plv) begin
            res.exc   = 1'b1;
            res.ecode = EC_PPI;
        end else if ((mem_type == MEM_STORE) && !half.d) begin
            res.exc   = 1'b1;
            res.ecode = EC_PME;
        end else begin
            res.valid = 1'b1;
            res.pa    = tlb_pa;
            res.mat   = half.mat;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) result_o <= '0;
        else       result_o <= en ? res : '0;
    end

endmodule

// File: rtl/tlb_mmu_mp.sv
// Multi-port TLB MMU: PORT_NUM one-cycle translation ports over shared
// entry storage, plus a maintenance FSM (search, read, write, fill,
// invalidate sweep).
//   clk   : clock
//   rst_n : async reset, active-high
//   flush : drops lookup results sampled this edge
//   csr   : crmd/asid/dmw snapshot
//   mp    : lookup + maintenance bus (slave side)
module tlb_mmu_mp
    import tlb_mmu_mp_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = 32,
    parameter int PORT_NUM      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  csr_t        csr,
    tlb_mmu_mp_if.slave mp
);

    localparam int IDX_W = $clog2(TLB_ENTRY_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_RESP} state_e;

    state_e                         state_q;
    tlb_entry_t [TLB_ENTRY_NUM-1:0] tlb_q;
    logic [IDX_W-1:0]               fill_ptr_q;
    logic [IDX_W-1:0]               sweep_idx_q;
    logic [2:0]                     inv_op_q;
    logic [9:0]                     inv_asid_q;
    logic [31:0]                    inv_va_q;
    logic                           ready_q, busy_q, resp_valid_q;
    tlb_maint_resp_t                resp_q;

    logic                           accept;
    logic [IDX_W-1:0]               req_idx;
    logic                           srch_found;
    logic [IDX_W-1:0]               srch_idx;
    trans_result_t [PORT_NUM-1:0]   lk_res;
    logic                           unused_idx_hi;

    assign accept        = mp.mt_valid_i & ready_q;
    assign req_idx       = mp.mt_req_i.index[IDX_W-1:0];
    assign unused_idx_hi = ^mp.mt_req_i.index;

    // ---------------- lookup ports ----------------
    // busy_q is the registered sweep flag, so a lookup sampled on any
    // edge of the sweep comes back invalid.
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        tlb_lookup_port #(
            .TLB_ENTRY_NUM(TLB_ENTRY_NUM)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (mp.lk_valid_i[p] & ~flush & ~busy_q),
            .csr      (csr),
            .va       (mp.lk_va_i[p]),
            .mem_type (mp.lk_mem_type_i[p]),
            .entries  (tlb_q),
            .result_o (lk_res[p])
        );
    end

    assign mp.lk_result_o     = lk_res;
    assign mp.mt_ready_o      = ready_q;
    assign mp.busy_o          = busy_q;
    assign mp.mt_resp_valid_o = resp_valid_q;
    assign mp.mt_resp_o       = resp_q;

    // ---------------- maintenance search ----------------
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = '0;
        for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
            if (!srch_found && tlb_match(tlb_q[i].key, mp.mt_req_i.va, mp.mt_req_i.asid)) begin
                srch_found = 1'b1;
                srch_idx   = IDX_W'(i);
            end
        end
    end

    // Free-running victim pointer for FILL.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) fill_ptr_q <= '0;
        else       fill_ptr_q <= fill_ptr_q + 1'b1;
    end

    // ---------------- maintenance FSM + entry storage ----------------
    // Writes land on the accept edge, so a same-cycle lookup still reads
    // the old contents.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            tlb_q        <= '0;
            sweep_idx_q  <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_va_q     <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q      <= 1'b0;
                        busy_q       <= (mp.mt_req_i.op == OP_INV);
                        resp_valid_q <= (mp.mt_req_i.op != OP_INV);
                        state_q      <= (mp.mt_req_i.op == OP_INV) ? ST_SWEEP : ST_RESP;
                        resp_q       <= '0;
                        case (mp.mt_req_i.op)
                            OP_SRCH: begin
                                resp_q.found <= srch_found;
                                resp_q.index <= TLB_IDX_W'(srch_idx);
                            end
                            OP_RD: begin
                                resp_q.found <= tlb_q[req_idx].key.e;
                                resp_q.index <= TLB_IDX_W'(req_idx);
                                resp_q.entry <= tlb_q[req_idx];
                            end
                            OP_WR: begin
                                tlb_q[req_idx] <= mp.mt_req_i.entry;
                                resp_q.index   <= TLB_IDX_W'(req_idx);
                                resp_q.entry   <= mp.mt_req_i.entry;
                            end
                            OP_FILL: begin
                                tlb_q[fill_ptr_q] <= mp.mt_req_i.entry;
                                resp_q.index      <= TLB_IDX_W'(fill_ptr_q);
                                resp_q.entry      <= mp.mt_req_i.entry;
                            end
                            OP_INV: begin
                                sweep_idx_q <= '0;
                                inv_op_q    <= mp.mt_req_i.inv_op;
                                inv_asid_q  <= mp.mt_req_i.asid;
                                inv_va_q    <= mp.mt_req_i.va;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SWEEP: begin
                    if (inv_hit(inv_op_q, tlb_q[sweep_idx_q].key, inv_asid_q, inv_va_q))
                        tlb_q[sweep_idx_q].key.e <= 1'b0;
                    sweep_idx_q <= sweep_idx_q + 1'b1;
                    if (sweep_idx_q == LAST_IDX) begin
                        state_q      <= ST_RESP;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_mmu_mp.sv
module tb_tlb_mmu_mp;
    import tlb_mmu_mp_pkg::*;

    localparam int N = 32;

    logic clk;
    logic rst;
    logic flush;
    csr_t csr;
    int   checks;
    int   errors;
    int unsigned cyc;

    tlb_mmu_mp_if #(.PORT_NUM(2)) mif ();

    tlb_mmu_mp #(.TLB_ENTRY_NUM(N), .PORT_NUM(2)) dut (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .csr   (csr),
        .mp    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release: the expected FILL victim index.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic tlb_entry_t mk(logic [18:0] vppn, logic huge, logic g, logic [9:0] asid,
                                      logic [19:0] ppn1, logic d1, logic v1);
        tlb_entry_t e;
        e = '0;
        e.key.vppn = vppn; e.key.huge = huge; e.key.g = g; e.key.asid = asid; e.key.e = 1'b1;
        e.v1.ppn = ppn1; e.v1.d = d1; e.v1.v = v1; e.v1.mat = 2'd1; e.v1.plv = 2'd0;
        return e;
    endfunction

    function automatic tlb_maint_req_t mreq(tlb_op_e op, logic [5:0] idx, tlb_entry_t e,
                                            logic [2:0] iop, logic [9:0] asid, logic [31:0] va);
        tlb_maint_req_t r;
        r.op = op; r.index = idx; r.entry = e; r.inv_op = iop; r.asid = asid; r.va = va;
        return r;
    endfunction

    // Presents a request for one edge; it is accepted there since the FSM is idle.
    task automatic mt_issue(tlb_maint_req_t r);
        mif.mt_req_i   = r;
        mif.mt_valid_i = 1'b1;
        tick();
        mif.mt_valid_i = 1'b0;
    endtask

    task automatic lk(int p, logic [31:0] va, logic [1:0] mt);
        mif.lk_valid_i[p]    = 1'b1;
        mif.lk_va_i[p]       = va;
        mif.lk_mem_type_i[p] = mt;
    endtask

    task automatic lk_clr();
        mif.lk_valid_i = '0;
    endtask

    // Waits out a sweep; returns edges from accept to the response pulse
    // (0 if it never came) and how many of those samples showed busy.
    task automatic wait_resp(output int n, output int busy_cnt);
        n = 1;
        busy_cnt = mif.busy_o ? 1 : 0;
        while (!mif.mt_resp_valid_o && n < 100) begin
            tick();
            n++;
            if (mif.busy_o) busy_cnt++;
        end
        if (!mif.mt_resp_valid_o) n = 0;
    endtask

    initial begin
        int n, bcnt, exp_fill;
        tlb_entry_t e3;
        checks = 0; errors = 0;
        rst = 1'b1; flush = 1'b0; csr = '0;
        mif.lk_valid_i = '0; mif.lk_va_i = '0; mif.lk_mem_type_i = '0;
        mif.mt_valid_i = 1'b0; mif.mt_req_i = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_res0", 64'(mif.lk_result_o[0]), 64'h0);
        chk("rst_res1", 64'(mif.lk_result_o[1]), 64'h0);
        chk("rst_resp_v", 64'(mif.mt_resp_valid_o), 64'h0);
        chk("rst_busy", 64'(mif.busy_o), 64'h0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 64'(mif.mt_ready_o), 64'h1);

        // ---- direct address ----
        csr.crmd.da = 1'b1; csr.crmd.datm = 2'd1; csr.crmd.datf = 2'd2; csr.asid = 10'd5;
        lk(0, 32'h0000_0ABC, MEM_FETCH);
        lk(1, 32'h1234_5678, MEM_LOAD);
        tick();
        chk("da_valid", 64'(mif.lk_result_o[1].valid), 64'h1);
        chk("da_pa", 64'(mif.lk_result_o[1].pa), 64'h1234_5678);
        chk("da_mat_m", 64'(mif.lk_result_o[1].mat), 64'h1);
        chk("da_mat_f", 64'(mif.lk_result_o[0].mat), 64'h2);
        csr.crmd.da = 1'b0;
        lk_clr();

        // ---- WR index 3; same-cycle lookup sees the old (empty) TLB ----
        e3 = mk(19'h00010, 1'b0, 1'b0, 10'd5, 20'hABCDE, 1'b1, 1'b1);
        lk(1, 32'h0002_1F00, MEM_LOAD);
        mt_issue(mreq(OP_WR, 6'd3, e3, 3'd0, 10'd0, 32'h0));
        chk("wr_pre_ecode", 64'(mif.lk_result_o[1].ecode), 64'(EC_TLBR));
        chk("wr_resp_v", 64'(mif.mt_resp_valid_o), 64'h1);
        chk("wr_resp_idx", 64'(mif.mt_resp_o.index), 64'd3);
        lk(0, 32'h0002_0F00, MEM_FETCH);
        tick();
        chk("wr_ready_back", 64'(mif.mt_ready_o), 64'h1);
        chk("tlb_pa", 64'(mif.lk_result_o[1].pa), 64'hABCD_EF00);
        chk("tlb_valid", 64'(mif.lk_result_o[1].valid), 64'h1);
        chk("tlb_exc", 64'(mif.lk_result_o[1].exc), 64'h0);
        chk("pif_ecode", 64'(mif.lk_result_o[0].ecode), 64'(EC_PIF));
        chk("pif_valid", 64'(mif.lk_result_o[0].valid), 64'h0);
        lk_clr();

        // ---- store to clean page, foreign asid ----
        e3.v1.d = 1'b0;
        mt_issue(mreq(OP_WR, 6'd3, e3, 3'd0, 10'd0, 32'h0));
        tick();
        lk(1, 32'h0002_1F00, MEM_STORE);
        tick();
        chk("pme_exc", 64'(mif.lk_result_o[1].exc), 64'h1);
        chk("pme_ecode", 64'(mif.lk_result_o[1].ecode), 64'(EC_PME));
        chk("pme_valid", 64'(mif.lk_result_o[1].valid), 64'h0);
        csr.asid = 10'd6;
        lk(1, 32'h0002_1F00, MEM_LOAD);
        tick();
        chk("asid_tlbr", 64'(mif.lk_result_o[1].ecode), 64'(EC_TLBR));
        csr.asid = 10'd5;

        // ---- DMW priority / PLV gating, PPI ----
        csr.dmw0 = '{vseg: 3'd4, pseg: 3'd2, mat: 2'd2, plv3: 1'b0, plv0: 1'b1};
        csr.dmw1 = '{vseg: 3'd4, pseg: 3'd1, mat: 2'd0, plv3: 1'b1, plv0: 1'b0};
        csr.crmd.plv = 2'd3;
        lk(0, 32'h8000_0040, MEM_FETCH);
        tick();
        chk("dmw1_pa", 64'(mif.lk_result_o[0].pa), 64'h2000_0040);
        chk("ppi_ecode", 64'(mif.lk_result_o[1].ecode), 64'(EC_PPI));
        csr.crmd.plv = 2'd0;
        tick();
        chk("dmw0_pa", 64'(mif.lk_result_o[0].pa), 64'h4000_0040);
        chk("dmw0_mat", 64'(mif.lk_result_o[0].mat), 64'h2);
        csr.dmw0 = '0; csr.dmw1 = '0;
        lk_clr();

        // ---- lowest index wins (lookup and search) ----
        mt_issue(mreq(OP_WR, 6'd9, mk(19'h00010, 1'b0, 1'b0, 10'd5, 20'h11111, 1'b1, 1'b1),
                      3'd0, 10'd0, 32'h0));
        tick();
        lk(1, 32'h0002_1F00, MEM_LOAD);
        mt_issue(mreq(OP_SRCH, 6'd0, '0, 3'd0, 10'd5, 32'h0002_1F00));
        chk("low_pa", 64'(mif.lk_result_o[1].pa), 64'hABCD_EF00);
        chk("srch_found", 64'(mif.mt_resp_o.found), 64'h1);
        chk("srch_idx", 64'(mif.mt_resp_o.index), 64'd3);
        tick();
        lk_clr();

        // ---- FILL a global huge page at the free-running pointer ----
        exp_fill = int'(cyc % N);
        mt_issue(mreq(OP_FILL, 6'd0, mk(19'h00200, 1'b1, 1'b1, 10'd0, 20'h12400, 1'b1, 1'b1),
                      3'd0, 10'd0, 32'h0));
        chk("fill_idx", 64'(mif.mt_resp_o.index), 64'(exp_fill));
        tick();

        // ---- two ports, flushed then repeated ----
        csr.dmw0 = '{vseg: 3'd5, pseg: 3'd0, mat: 2'd1, plv3: 1'b0, plv0: 1'b1};
        lk(0, 32'hA000_1000, MEM_FETCH);
        lk(1, 32'h0060_0ABC, MEM_LOAD);
        flush = 1'b1;
        tick();
        chk("flush_v0", 64'(mif.lk_result_o[0].valid), 64'h0);
        chk("flush_v1", 64'(mif.lk_result_o[1].valid), 64'h0);
        flush = 1'b0;
        tick();
        chk("mp_pa0", 64'(mif.lk_result_o[0].pa), 64'h0000_1000);
        chk("mp_v0", 64'(mif.lk_result_o[0].valid), 64'h1);
        chk("mp_pa1", 64'(mif.lk_result_o[1].pa), 64'h1240_0ABC);
        chk("mp_v1", 64'(mif.lk_result_o[1].valid), 64'h1);
        lk_clr();
        csr.dmw0 = '0;

        // ---- INV all; flush mid-sweep must not abort it, lookups blocked ----
        mt_issue(mreq(OP_INV, 6'd0, '0, INV_ALL0, 10'd0, 32'h0));
        flush = 1'b1;
        tick(); tick();
        flush = 1'b0;
        lk(1, 32'h0002_1F00, MEM_LOAD);
        tick(); tick();
        chk("busy_lk", 64'(mif.lk_result_o[1]), 64'h0);
        lk_clr();
        n = 0; bcnt = 0;
        begin
            int k, b;
            wait_resp(k, b);
            n = (k == 0) ? 0 : k + 4;
            bcnt = b + 4;
        end
        chk("inv_busy_cycles", 64'(bcnt), 64'd32);
        chk("inv_resp_cycle", 64'(n), 64'd33);
        tick();
        chk("inv_pulse_1cyc", 64'(mif.mt_resp_valid_o), 64'h0);
        mt_issue(mreq(OP_SRCH, 6'd0, '0, 3'd0, 10'd5, 32'h0002_1F00));
        chk("inv_srch", 64'(mif.mt_resp_o.found), 64'h0);
        tick();

        // ---- selective INV (g=0 & asid) ----
        mt_issue(mreq(OP_WR, 6'd1, mk(19'h00040, 1'b0, 1'b1, 10'd5, 20'h1, 1'b1, 1'b1), 3'd0, 10'd0, 32'h0));
        tick();
        mt_issue(mreq(OP_WR, 6'd2, mk(19'h00041, 1'b0, 1'b0, 10'd5, 20'h2, 1'b1, 1'b1), 3'd0, 10'd0, 32'h0));
        tick();
        mt_issue(mreq(OP_INV, 6'd0, '0, INV_G0_ASID, 10'd5, 32'h0));
        wait_resp(n, bcnt);
        chk("inv4_done", 64'(n), 64'd33);
        tick();
        mt_issue(mreq(OP_RD, 6'd1, '0, 3'd0, 10'd0, 32'h0));
        chk("inv4_keep_g", 64'(mif.mt_resp_o.found), 64'h1);
        chk("rd_vppn", 64'(mif.mt_resp_o.entry.key.vppn), 64'h40);
        tick();
        mt_issue(mreq(OP_RD, 6'd2, '0, 3'd0, 10'd0, 32'h0));
        chk("inv4_clr", 64'(mif.mt_resp_o.found), 64'h0);
        tick();

        // ---- reset in the middle of a sweep ----
        mt_issue(mreq(OP_WR, 6'd20, mk(19'h00050, 1'b0, 1'b1, 10'd0, 20'h3, 1'b1, 1'b1), 3'd0, 10'd0, 32'h0));
        tick();
        mt_issue(mreq(OP_INV, 6'd0, '0, INV_ALL0, 10'd0, 32'h0));
        for (int i = 0; i < 9; i++) tick();
        chk("sweep_busy", 64'(mif.busy_o), 64'h1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 64'(mif.busy_o), 64'h0);
        chk("mrst_resp", 64'(mif.mt_resp_valid_o), 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_resp2", 64'(mif.mt_resp_valid_o), 64'h0);
        chk("mrst_ready", 64'(mif.mt_ready_o), 64'h1);
        mt_issue(mreq(OP_RD, 6'd20, '0, 3'd0, 10'd0, 32'h0));
        chk("mrst_e20", 64'(mif.mt_resp_o.found), 64'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
